regression_train_controller: RTL and testbench

//  Sequences one training pass of the linear-regression coefficient datapath.

---
 rtl/regression_train_controller.sv | 160 ++++++++++++++++
 tb/tb_regression_train_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regression_train_controller.sv
// regression_train_controller
// Sequences one training pass of the linear-regression coefficient datapath:
// clears the calculator, streams N_SAMPLES (x,y) pairs from sample memory into
// it with single-cycle enables, then latches B0/B1 into held registers.
// Optional feature macro: REG_PREDICT_EN adds a query port that evaluates
// y = b0 + b1*x with the held coefficients.
module regression_train_controller #(
    parameter int N_SAMPLES = 1000,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 20,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              coef_valid,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_x,
    input  logic [DATA_W-1:0] mem_y,
    output logic              calc_clr,
    output logic              calc_en,
    output logic [DATA_W-1:0] calc_x,
    output logic [DATA_W-1:0] calc_y,
    input  logic [DATA_W-1:0] calc_b0,
    input  logic [DATA_W-1:0] calc_b1,
    output logic [DATA_W-1:0] b0,
    output logic [DATA_W-1:0] b1
`ifdef REG_PREDICT_EN
    ,
    input  logic              q_valid,
    input  logic [DATA_W-1:0] q_x,
    output logic              p_valid,
    output logic [DATA_W-1:0] p_y
`endif
);

    localparam int                WC_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WC_W-1:0]   WC_LAST  = WC_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_SAMPLES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT, FEED, SETTLE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [WC_W-1:0]   wcnt;

    // The sample index is itself the memory address; it only changes on entry to FETCH.
    assign mem_addr = idx;

    // Pass sequencer; every output is registered and set on entry to the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            wcnt       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            coef_valid <= 1'b0;
            mem_rd     <= 1'b0;
            calc_clr   <= 1'b0;
            calc_en    <= 1'b0;
            calc_x     <= '0;
            calc_y     <= '0;
            b0         <= '0;
            b1         <= '0;
        end else begin
            mem_rd   <= 1'b0;
            calc_clr <= 1'b0;
            calc_en  <= 1'b0;
            done     <= 1'b0;
            if (abort && state != IDLE && state != DONE) begin
                // Cancelled pass: held coefficients keep their old value but are no longer trusted.
                state      <= IDLE;
                busy       <= 1'b0;
                coef_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state      <= CLEAR;
                            busy       <= 1'b1;
                            calc_clr   <= 1'b1;
                            coef_valid <= 1'b0;
                            idx        <= '0;
                        end
                    end
                    CLEAR: begin
                        state  <= FETCH;
                        mem_rd <= 1'b1;
                    end
                    FETCH: begin
                        state <= WAIT;
                        wcnt  <= '0;
                    end
                    WAIT: begin
                        if (wcnt == WC_LAST) begin
                            state   <= FEED;
                            calc_x  <= mem_x;
                            calc_y  <= mem_y;
                            calc_en <= 1'b1;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                    FEED: begin
                        // Stop at the last index instead of incrementing, so a full-range pass never wraps.
                        if (idx == IDX_LAST) begin
                            state <= SETTLE;
                        end else begin
                            state  <= FETCH;
                            idx    <= idx + 1'b1;
                            mem_rd <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        state      <= DONE;
                        b0         <= calc_b0;
                        b1         <= calc_b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        coef_valid <= 1'b1;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef REG_PREDICT_EN
    logic [2*DATA_W-1:0] prod;

    // Full-width product so the Q10.10 rescale keeps every integer bit before truncation.
    assign prod = {{DATA_W{1'b0}}, b1} * {{DATA_W{1'b0}}, q_x};

    // Prediction is only answered from a settled, valid coefficient set while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid <= 1'b0;
            p_y     <= '0;
        end else begin
            p_valid <= 1'b0;
            if (q_valid && coef_valid && state == IDLE) begin
                p_valid <= 1'b1;
                p_y     <= b0 + DATA_W'(prod >> 10);
            end
        end
    end
`endif

endmodule

// File: tb/tb_regression_train_controller.sv
// Testbench for regression_train_controller: two instances (RD_LAT 1 and 3,
// N_SAMPLES 4 with ADDR_W 2 so the index reaches all-ones), each with a
// sample memory model, a least-squares calculator model and a scoreboard.
module tb_regression_train_controller;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 20;

    int checks   = 0;
    int failures = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;

    always #5 clk = ~clk;

    logic          busy [2];
    logic          done [2];
    logic          coef_valid [2];
    logic          mem_rd [2];
    logic          calc_clr [2];
    logic          calc_en [2];
    logic [AW-1:0] mem_addr [2];
    logic [DW-1:0] calc_x [2];
    logic [DW-1:0] calc_y [2];
    logic [DW-1:0] b0 [2];
    logic [DW-1:0] b1 [2];
`ifdef REG_PREDICT_EN
    logic          q_valid = 1'b0;
    logic [DW-1:0] q_x = '0;
    logic          p_valid [2];
    logic [DW-1:0] p_y [2];
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] xval(input int a);
        return DW'((a + 1) << 10);
    endfunction

    function automatic logic [DW-1:0] yval(input int a);
        return DW'((2 * a + 3) << 10);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : env
        localparam int LAT     = (g == 0) ? 1 : 3;
        localparam int LATENCY = 2 + N * (LAT + 2) + 1;

        logic [LAT-1:0] vpipe = '0;
        logic [AW-1:0]  apipe [LAT];
        logic [DW-1:0]  mx, my, cb0, cb1;
        longint         n = 0, sx = 0, sy = 0, sxx = 0, sxy = 0;
        longint         den, b0m, b1m;
        logic [DW-1:0]  exp_xq [$];
        logic [DW-1:0]  exp_yq [$];
        logic [AW-1:0]  rd_q [$];
        logic [2*DW-1:0] coef_q [$];
        logic [2*DW-1:0] ec;
        int             cyc = 0;
        int             last_en = 0;

        regression_train_controller #(
            .N_SAMPLES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)
        ) dut (
            .clk(clk), .reset(reset), .start(start), .abort(abort),
            .busy(busy[g]), .done(done[g]), .coef_valid(coef_valid[g]),
            .mem_rd(mem_rd[g]), .mem_addr(mem_addr[g]),
            .mem_x(mx), .mem_y(my),
            .calc_clr(calc_clr[g]), .calc_en(calc_en[g]),
            .calc_x(calc_x[g]), .calc_y(calc_y[g]),
            .calc_b0(cb0), .calc_b1(cb1),
            .b0(b0[g]), .b1(b1[g])
`ifdef REG_PREDICT_EN
            ,
            .q_valid(q_valid), .q_x(q_x), .p_valid(p_valid[g]), .p_y(p_y[g])
`endif
        );

        // Sample memory: data is driven only in the exact cycle RD_LAT after the read strobe.
        always @(posedge clk) begin
            for (int k = LAT - 1; k > 0; k--) begin
                vpipe[k] <= vpipe[k-1];
                apipe[k] <= apipe[k-1];
            end
            vpipe[0] <= mem_rd[g];
            apipe[0] <= mem_addr[g];
        end
        assign mx = vpipe[LAT-1] ? xval(int'(apipe[LAT-1])) : 20'hABCDE;
        assign my = vpipe[LAT-1] ? yval(int'(apipe[LAT-1])) : 20'h5A5A5;

        // Least-squares calculator model, accumulating on calc_en, cleared by calc_clr.
        always @(posedge clk) begin
            if (reset || calc_clr[g]) begin
                n <= 0; sx <= 0; sy <= 0; sxx <= 0; sxy <= 0;
            end else if (calc_en[g]) begin
                n   <= n + 1;
                sx  <= sx + longint'(calc_x[g]);
                sy  <= sy + longint'(calc_y[g]);
                sxx <= sxx + longint'(calc_x[g]) * longint'(calc_x[g]);
                sxy <= sxy + longint'(calc_x[g]) * longint'(calc_y[g]);
            end
        end
        always_comb begin
            b0m = 0;
            b1m = 0;
            den = n * sxx - sx * sx;
            if (n > 0 && den != 0) begin
                b1m = ((n * sxy - sx * sy) * 1024) / den;
                b0m = (sy - ((b1m * sx) >>> 10)) / n;
            end
        end
        assign cb0 = DW'(b0m);
        assign cb1 = DW'(b1m);

        // Scoreboard push on an accepted start; flush on reset or abort of a running pass.
        always @(posedge clk) begin
            cyc <= cyc + 1;
            if (reset || (abort && busy[g])) begin
                exp_xq.delete(); exp_yq.delete(); rd_q.delete(); coef_q.delete();
            end else if (start && !abort && !busy[g] && !done[g]) begin
                cyc <= 1;
                exp_xq.delete(); exp_yq.delete(); rd_q.delete(); coef_q.delete();
                for (int k = 0; k < N; k++) begin
                    exp_xq.push_back(xval(k));
                    exp_yq.push_back(yval(k));
                    rd_q.push_back(AW'(k));
                end
                coef_q.push_back({20'h00400, 20'h00800});
            end
        end

        // Scoreboard pop/compare on every DUT event.
        always @(negedge clk) begin
            if (mem_rd[g]) begin
                chk($sformatf("e%0d_rd_pending", g), 64'(rd_q.size() != 0), 64'(1));
                if (rd_q.size() != 0)
                    chk($sformatf("e%0d_mem_addr", g), 64'(mem_addr[g]), 64'(rd_q.pop_front()));
            end
            if (calc_en[g]) begin
                chk($sformatf("e%0d_en_pending", g), 64'(exp_xq.size() != 0), 64'(1));
                if (exp_xq.size() != 0) begin
                    chk($sformatf("e%0d_calc_x", g), 64'(calc_x[g]), 64'(exp_xq.pop_front()));
                    chk($sformatf("e%0d_calc_y", g), 64'(calc_y[g]), 64'(exp_yq.pop_front()));
                    if (exp_xq.size() != N - 1)
                        chk($sformatf("e%0d_en_spacing", g), 64'(cyc - last_en), 64'(LAT + 2));
                    last_en <= cyc;
                end
            end
            if (done[g]) begin
                chk($sformatf("e%0d_done_pending", g), 64'(coef_q.size() != 0), 64'(1));
                if (coef_q.size() != 0) begin
                    ec = coef_q.pop_front();
                    chk($sformatf("e%0d_b0", g), 64'(b0[g]), 64'(ec[2*DW-1:DW]));
                    chk($sformatf("e%0d_b1", g), 64'(b1[g]), 64'(ec[DW-1:0]));
                    chk($sformatf("e%0d_coef_valid", g), 64'(coef_valid[g]), 64'(1));
                    chk($sformatf("e%0d_latency", g), 64'(cyc), 64'(LATENCY));
                    chk($sformatf("e%0d_feeds_left", g), 64'(exp_xq.size()), 64'(0));
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int max, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (done[idx]) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'(1));
    endtask

    task automatic chk_reset_state(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_ctl%0d", tag, g),
                64'({busy[g], done[g], coef_valid[g], mem_rd[g], mem_addr[g], calc_clr[g], calc_en[g]}), 64'(0));
            chk($sformatf("%s_data%0d", tag, g), 64'({calc_x[g], calc_y[g], b0[g]}), 64'(0));
            chk($sformatf("%s_b1_%0d", tag, g), 64'(b1[g]), 64'(0));
`ifdef REG_PREDICT_EN
            chk($sformatf("%s_pred%0d", tag, g), 64'({p_valid[g], p_y[g]}), 64'(0));
`endif
        end
    endtask

    initial begin
        int c;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("rst");
        reset = 1'b0;

        // Single pass on both read latencies
        pulse_start();
        wait_done(1, 60, "t1_done");
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("t1_hold_b0_%0d", g), 64'(b0[g]), 64'(20'h00400));
            chk($sformatf("t1_hold_b1_%0d", g), 64'(b1[g]), 64'(20'h00800));
            chk($sformatf("t1_hold_cv_%0d", g), 64'(coef_valid[g]), 64'(1));
        end

`ifdef REG_PREDICT_EN
        q_x = 20'h01400;
        @(negedge clk) q_valid = 1'b1;
        @(negedge clk) q_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("p_valid_%0d", g), 64'(p_valid[g]), 64'(1));
            chk($sformatf("p_y_%0d", g), 64'(p_y[g]), 64'(20'h02C00));
        end
        @(negedge clk);
        chk("p_valid_pulse", 64'(p_valid[0]), 64'(0));
`endif

        // Restart attempt while busy is ignored
        pulse_start();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
`ifdef REG_PREDICT_EN
        q_valid = 1'b1;
        @(negedge clk) q_valid = 1'b0;
        chk("p_busy_ignored", 64'({p_valid[0], p_valid[1]}), 64'(0));
`endif
        wait_done(1, 60, "t3_done");
        repeat (6) @(negedge clk);

        // Abort during the second feed of the RD_LAT=1 instance
        pulse_start();
        c = 0;
        for (int i = 0; i < 40 && c < 2; i++) begin
            @(negedge clk);
            if (calc_en[0]) c++;
        end
        chk("t4_second_feed", 64'(c), 64'(2));
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("t4_busy_%0d", g), 64'(busy[g]), 64'(0));
            chk($sformatf("t4_cv_%0d", g), 64'(coef_valid[g]), 64'(0));
            chk($sformatf("t4_b0_%0d", g), 64'(b0[g]), 64'(20'h00400));
            chk($sformatf("t4_b1_%0d", g), 64'(b1[g]), 64'(20'h00800));
        end
        repeat (30) @(negedge clk);
`ifdef REG_PREDICT_EN
        q_valid = 1'b1;
        @(negedge clk) q_valid = 1'b0;
        chk("p_invalid_ignored", 64'({p_valid[0], p_valid[1]}), 64'(0));
`endif
        pulse_start();
        wait_done(1, 60, "t4_restart_done");
        repeat (3) @(negedge clk);

        // start and abort together while idle: abort wins
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        repeat (3) @(negedge clk);
        chk("sa_idle_busy", 64'({busy[0], busy[1]}), 64'(0));
        chk("sa_idle_cv", 64'({coef_valid[0], coef_valid[1]}), 64'(2'b11));

        // Reset while the RD_LAT=1 instance is in WAIT
        pulse_start();
        c = 0;
        for (int i = 0; i < 20 && c == 0; i++) begin
            @(negedge clk);
            if (mem_rd[0]) c = 1;
        end
        chk("t5_fetch_seen", 64'(c), 64'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_state("t5");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_stays_idle", 64'({busy[0], busy[1], done[0], done[1]}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
